// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the shared memory port
// seen by mem_port_arbiter.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_stall;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic        d_sign;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_stall;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  // Requesters plus memory: drive the requests and the memory response.
  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_size, d_sign,
           mem_rdata, mem_ready,
    input  if_ack, if_rdata, if_stall, d_ack, d_rdata, d_stall,
           mem_addr, mem_wdata, mem_size, mem_sign, mem_we
  );

  // The arbiter itself.
  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_size, d_sign,
           mem_rdata, mem_ready,
    output if_ack, if_rdata, if_stall, d_ack, d_rdata, d_stall,
           mem_addr, mem_wdata, mem_size, mem_sign, mem_we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store,
// with fixed data priority and fetch cancellation on branch flush.
module mem_port_arbiter (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC_IF, ACC_D} state_t;

  state_t      state, state_next;
  logic        elig_if, elig_d;
  logic        if_done, d_done, if_cancel;
  logic        if_kill, if_kill_next;
  logic        if_ack_q, d_ack_q;
  logic [31:0] if_rdata_q, d_rdata_q;

  // A requester is locked out during its own access and its ack cycle.
  assign elig_if = bus.if_req && (state != ACC_IF) && !if_ack_q;
  assign elig_d  = bus.d_req  && (state != ACC_D)  && !d_ack_q;

  assign if_done   = (state == ACC_IF) && bus.mem_ready;
  assign d_done    = (state == ACC_D)  && bus.mem_ready;
  assign if_cancel = if_kill || bus.if_flush;

  // NOTE: every always_comb output gets a default before any branch so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    if_kill_next = 1'b0;
    if ((state == IDLE) || bus.mem_ready) begin
      if (elig_d)       state_next = ACC_D;
      else if (elig_if) state_next = ACC_IF;
      else              state_next = IDLE;
    end
    // Remember a flush seen at grant or during a stalled fetch so the ack
    // is still dropped when mem_ready finally arrives.
    if ((state == ACC_IF) && !bus.mem_ready)
      if_kill_next = if_kill || bus.if_flush;
    else if (state_next == ACC_IF)
      if_kill_next = bus.if_flush;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      if_kill    <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state    <= state_next;
      if_kill  <= if_kill_next;
      if_ack_q <= if_done && !if_cancel;
      d_ack_q  <= d_done;
      if (if_done && !if_cancel) if_rdata_q <= bus.mem_rdata;
      if (d_done)                d_rdata_q  <= bus.mem_rdata;
    end
  end

  // Memory port is steered by the owner; forced quiet while reset is held.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_size  = '0;
    bus.mem_sign  = 1'b0;
    bus.mem_we    = 1'b0;
    if (!rst) begin
      case (state)
        ACC_IF: begin
          bus.mem_addr = bus.if_addr;
          bus.mem_size = 2'b10;
        end
        ACC_D: begin
          bus.mem_addr  = bus.d_addr;
          bus.mem_wdata = bus.d_wdata;
          bus.mem_size  = bus.d_size;
          bus.mem_sign  = bus.d_sign;
          bus.mem_we    = bus.d_we;
        end
        default: ;
      endcase
    end
  end

  assign bus.if_ack   = if_ack_q;
  assign bus.d_ack    = d_ack_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.if_stall = bus.if_req && !if_ack_q;
  assign bus.d_stall  = bus.d_req  && !d_ack_q;

endmodule
